// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bus of the mem_arbiter.
// The arbiter connects through the slave modport; the requesters and the memory use master.
`timescale 1ns/1ps
interface mem_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS-1:0]        rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic                        rsp_err;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_re;
    logic                        mem_wr;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        mem_ready;
    logic                        busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output mem_addr, mem_wdata, mem_re, mem_wr, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_addr, mem_wdata, mem_re, mem_wr, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Registered N-port arbiter onto a single memory port: latches the winning request,
// holds strobes until mem_ready (or timeout) and pulses a response to the owner only.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RR_MODE   = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned NP = NUM_PORTS;
    localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    logic [OW-1:0]         r_owner;
    logic [OW-1:0]         r_ptr;
    logic [TW-1:0]         r_cnt;
    logic [NUM_PORTS-1:0]  r_req_ready;
    logic [NUM_PORTS-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_data;
    logic                  r_rsp_err;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic                  r_mem_re;
    logic                  r_mem_wr;
    logic                  r_busy;

    logic [OW-1:0]         w_win;
    logic                  w_any;
    logic [NUM_PORTS-1:0]  w_win_oh;
    logic [NUM_PORTS-1:0]  w_own_oh;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     w_wdata;
    logic                  w_we;
    logic                  w_timeout;

    // Winner selection: highest valid index, or round-robin search starting after r_ptr.
    always_comb begin
        logic [OW-1:0] idx;
        logic          found;
        w_win = '0;
        idx   = '0;
        found = 1'b0;
        w_any = |bus.req_valid;
        if (RR_MODE != 0) begin
            for (int unsigned k = 1; k <= NP; k++) begin
                idx = OW'((32'(r_ptr) + k) % NP);
                if (!found && bus.req_valid[idx]) begin
                    w_win = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < NP; i++) begin
                if (bus.req_valid[i]) begin
                    w_win = OW'(i);
                end
            end
        end
    end

    // Payload mux for the selected port.
    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (w_win == OW'(i)) begin
                w_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                w_we    = bus.req_we[i];
            end
        end
    end

    assign w_win_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_win;
    assign w_own_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_owner;
    // Abort on the edge where the low-ready count would reach TIMEOUT, so the
    // strobe is high for exactly TIMEOUT cycles.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TW'(TIMEOUT - 1));

    // Arbitration FSM with registered grant, strobe and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_ptr       <= OW'(NUM_PORTS - 1);
            r_cnt       <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_BUSY;
                        r_owner     <= w_win;
                        r_req_ready <= w_win_oh;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_mem_re    <= ~w_we;
                        r_mem_wr    <= w_we;
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                        if (RR_MODE != 0) begin
                            r_ptr <= w_win;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= w_own_oh;
                        r_rsp_data  <= r_mem_re ? bus.mem_rdata : '0;
                        r_rsp_err   <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_mem_re    <= 1'b0;
                        r_mem_wr    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                    end else if (w_timeout) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= w_own_oh;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_mem_re    <= 1'b0;
                        r_mem_wr    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                    end else if (TIMEOUT != 0 && r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_re    = r_mem_re;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.busy      = r_busy;
endmodule
